// File: rtl/rtc_alarm_pkg.sv
// rtc_alarm_pkg
//   Shared definitions for the RTC alarm/interrupt generator: channel state
//   encoding, channel mode constants and default sizing.
package rtc_alarm_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRED = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/rtc_alarm_ch.sv
// rtc_alarm_ch
//   One RTC alarm channel: IDLE/ARMED/FIRED state, match register with
//   optional periodic reload, sticky interrupt and overrun flags, and a
//   one-cycle trigger pulse per hit.
// Ports
//   clk, rst_n          RTC clock, async active-low reset
//   cnt_en, count_val   RTC counter running flag and current count
//   ld, dis, ld_val     arm (load match) / disarm pulses, load value
//   mode, period        one-shot/periodic select, reload increment
//   intr_en, int_clr    flag set enable, flag clear (level)
//   int_flag, ovr_flag  sticky interrupt / overrun flags
//   armed, etb_trig     channel armed, one-cycle hit pulse
module rtc_alarm_ch
  import rtc_alarm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic [CNT_W-1:0] count_val,
  input  logic             ld,
  input  logic             dis,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic             intr_en,
  input  logic             int_clr,
  output logic             int_flag,
  output logic             ovr_flag,
  output logic             armed,
  output logic             etb_trig
);

  logic [1:0]       state;
  logic [CNT_W-1:0] match;
  logic             hit;
  logic             reload;

  assign hit    = (state == ST_ARMED) && cnt_en && (count_val == match);
  assign reload = (mode != MODE_ONESHOT) && (period != '0);
  assign armed  = (state == ST_ARMED);

  // Disarm beats load, load beats reload; a hit in the same cycle still
  // reports against the old match (see flag block) but never reloads here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      match <= '0;
    end else if (dis) begin
      state <= ST_IDLE;
    end else if (ld) begin
      state <= ST_ARMED;
      match <= ld_val;
    end else if (hit) begin
      if (reload) match <= match + period;
      else        state <= ST_FIRED;
    end
  end

  // Set wins over clear, so a hit coinciding with int_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_flag <= 1'b0;
      ovr_flag <= 1'b0;
      etb_trig <= 1'b0;
    end else begin
      etb_trig <= hit;
      if (hit && intr_en)      int_flag <= 1'b1;
      else if (int_clr)        int_flag <= 1'b0;
      if (hit && intr_en && int_flag && !int_clr) ovr_flag <= 1'b1;
      else if (int_clr)                           ovr_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_alarm_ig.sv
// rtc_alarm_ig
//   Multi-channel RTC alarm/interrupt generator. Compares the RTC count
//   against NUM_CH independently armed match registers and merges the
//   unmasked interrupt flags into a single VIC line.
// Ports
//   i_rtc_ext_clk, rtc_por_rst_n   RTC clock, async active-low POR
//   cnt_en, count_val              RTC counter running flag and count
//   ch_ld, ch_dis, ld_val          per-channel arm/disarm pulses, load value
//   ch_mode, ch_period             per-channel mode and packed periods
//   intr_en, intr_mask, int_clr    per-channel flag enable, VIC mask, clear
//   int_flag, ovr_flag             per-channel sticky flags
//   ch_armed, rtc_etb_trig         per-channel armed state, hit pulse
//   rtc0_vic_intr                  merged interrupt
module rtc_alarm_ig
  import rtc_alarm_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    i_rtc_ext_clk,
  input  logic                    rtc_por_rst_n,
  input  logic                    cnt_en,
  input  logic [CNT_W-1:0]        count_val,
  input  logic [NUM_CH-1:0]       ch_ld,
  input  logic [NUM_CH-1:0]       ch_dis,
  input  logic [CNT_W-1:0]        ld_val,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH*CNT_W-1:0] ch_period,
  input  logic [NUM_CH-1:0]       intr_en,
  input  logic [NUM_CH-1:0]       intr_mask,
  input  logic [NUM_CH-1:0]       int_clr,
  output logic [NUM_CH-1:0]       int_flag,
  output logic [NUM_CH-1:0]       ovr_flag,
  output logic [NUM_CH-1:0]       ch_armed,
  output logic [NUM_CH-1:0]       rtc_etb_trig,
  output logic                    rtc0_vic_intr
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rtc_alarm_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (i_rtc_ext_clk),
      .rst_n     (rtc_por_rst_n),
      .cnt_en    (cnt_en),
      .count_val (count_val),
      .ld        (ch_ld[i]),
      .dis       (ch_dis[i]),
      .ld_val    (ld_val),
      .mode      (ch_mode[i]),
      .period    (ch_period[i*CNT_W +: CNT_W]),
      .intr_en   (intr_en[i]),
      .int_clr   (int_clr[i]),
      .int_flag  (int_flag[i]),
      .ovr_flag  (ovr_flag[i]),
      .armed     (ch_armed[i]),
      .etb_trig  (rtc_etb_trig[i])
    );
  end

  // int_clr gates the line combinationally so it drops in the clear cycle.
  assign rtc0_vic_intr = |(int_flag & ~intr_mask & ~int_clr);

endmodule

// File: tb/tb_rtc_alarm_ig.sv
module tb_rtc_alarm_ig;

  localparam logic [3:0] Z = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 4-channel, 32-bit instance
  logic        cnt_en;
  logic [31:0] count_val, ld_val;
  logic [3:0]  ch_ld, ch_dis, ch_mode, intr_en, intr_mask, int_clr;
  logic [127:0] ch_period;
  logic [3:0]  int_flag, ovr_flag, ch_armed, rtc_etb_trig;
  logic        rtc0_vic_intr;

  // 1-channel, 8-bit instance for wrap-around
  logic        n_cnt_en;
  logic [7:0]  n_count, n_ld_val, n_period;
  logic [0:0]  n_ld, n_dis, n_mode, n_ien, n_mask, n_clr;
  logic [0:0]  n_flag, n_ovr, n_armed, n_trig;
  logic        n_vic;

  rtc_alarm_ig #(.NUM_CH(4), .CNT_W(32)) dut (
    .i_rtc_ext_clk(clk), .rtc_por_rst_n(rst_n), .cnt_en(cnt_en),
    .count_val(count_val), .ch_ld(ch_ld), .ch_dis(ch_dis), .ld_val(ld_val),
    .ch_mode(ch_mode), .ch_period(ch_period), .intr_en(intr_en),
    .intr_mask(intr_mask), .int_clr(int_clr), .int_flag(int_flag),
    .ovr_flag(ovr_flag), .ch_armed(ch_armed), .rtc_etb_trig(rtc_etb_trig),
    .rtc0_vic_intr(rtc0_vic_intr)
  );

  rtc_alarm_ig #(.NUM_CH(1), .CNT_W(8)) dut8 (
    .i_rtc_ext_clk(clk), .rtc_por_rst_n(rst_n), .cnt_en(n_cnt_en),
    .count_val(n_count), .ch_ld(n_ld), .ch_dis(n_dis), .ld_val(n_ld_val),
    .ch_mode(n_mode), .ch_period(n_period), .intr_en(n_ien),
    .intr_mask(n_mask), .int_clr(n_clr), .int_flag(n_flag),
    .ovr_flag(n_ovr), .ch_armed(n_armed), .rtc_etb_trig(n_trig),
    .rtc0_vic_intr(n_vic)
  );

  typedef struct {
    logic [31:0] count;
    logic        en;
    logic [3:0]  ld, dis;
    logic [31:0] ldv;
    logic [3:0]  mode;
    logic [31:0] period;
    logic [3:0]  ien, mask, clr;
    logic [3:0]  ef, eo, ea, et;
    logic        ev;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] ef, eo, ea, et;
    logic       ev;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] count, input logic en,
                              input logic [3:0] ld, input logic [3:0] dis,
                              input logic [31:0] ldv, input logic [3:0] mode,
                              input logic [31:0] period, input logic [3:0] ien,
                              input logic [3:0] mask, input logic [3:0] clr,
                              input logic [3:0] ef, input logic [3:0] eo,
                              input logic [3:0] ea, input logic [3:0] et,
                              input logic ev);
    vec_t v;
    v.count = count; v.en = en; v.ld = ld; v.dis = dis; v.ldv = ldv;
    v.mode = mode; v.period = period; v.ien = ien; v.mask = mask; v.clr = clr;
    v.ef = ef; v.eo = eo; v.ea = ea; v.et = et; v.ev = ev;
    vq.push_back(v);
  endfunction

  // Each vector's inputs are held across one rising edge; outputs are sampled
  // 1 time unit later, while those inputs are still applied.
  task automatic run_table();
    vec_t v;
    exp_t e;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      count_val = v.count; cnt_en = v.en; ch_ld = v.ld; ch_dis = v.dis;
      ld_val = v.ldv; ch_mode = v.mode; ch_period = {4{v.period}};
      intr_en = v.ien; intr_mask = v.mask; int_clr = v.clr;
      e.idx = vec_idx; e.ef = v.ef; e.eo = v.eo; e.ea = v.ea; e.et = v.et; e.ev = v.ev;
      sb.push_back(e);
      vec_idx++;
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d int_flag", e.idx), 32'(int_flag), 32'(e.ef));
      chk($sformatf("v%0d ovr_flag", e.idx), 32'(ovr_flag), 32'(e.eo));
      chk($sformatf("v%0d ch_armed", e.idx), 32'(ch_armed), 32'(e.ea));
      chk($sformatf("v%0d etb_trig", e.idx), 32'(rtc_etb_trig), 32'(e.et));
      chk($sformatf("v%0d vic", e.idx), 32'(rtc0_vic_intr), 32'(e.ev));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_en = 1'b0; count_val = '0; ld_val = '0; ch_ld = '0; ch_dis = '0;
    ch_mode = '0; ch_period = '0; intr_en = '0; intr_mask = '0; int_clr = '0;
    n_cnt_en = 1'b0; n_count = '0; n_ld_val = '0; n_period = '0; n_ld = '0;
    n_dis = '0; n_mode = '0; n_ien = '0; n_mask = '0; n_clr = '0;
    #12;
    chk("rst int_flag", 32'(int_flag), 32'h0);
    chk("rst ch_armed", 32'(ch_armed), 32'h0);
    chk("rst vic", 32'(rtc0_vic_intr), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // One-shot on ch0 at 100
    add(0,   1'b0, Z,    Z, 100, Z, 0, Z,    Z, Z,    Z,    Z, Z,    Z,    1'b0);
    add(0,   1'b0, 4'h1, Z, 100, Z, 0, 4'h1, Z, Z,    Z,    Z, 4'h1, Z,    1'b0);
    add(98,  1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    Z,    Z, 4'h1, Z,    1'b0);
    add(99,  1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    Z,    Z, 4'h1, Z,    1'b0);
    add(100, 1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    4'h1, Z, Z,    4'h1, 1'b1);
    add(101, 1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    4'h1, Z, Z,    Z,    1'b1);
    add(102, 1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    4'h1, Z, Z,    Z,    1'b1);
    add(100, 1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    4'h1, Z, Z,    Z,    1'b1);
    add(103, 1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, 4'h1, Z,    Z, Z,    Z,    1'b0);
    add(103, 1'b1, Z,    Z, 100, Z, 0, 4'h1, Z, Z,    Z,    Z, Z,    Z,    1'b0);
    // Periodic ch1 from 10 step 5, intr_en off: trig only
    add(0, 1'b0, 4'h2, Z, 10, 4'h2, 5, Z, Z, Z, Z, Z, 4'h2, Z, 1'b0);
    for (int c = 0; c <= 40; c++)
      add(c, 1'b1, Z, Z, 10, 4'h2, 5, Z, Z, Z, Z, Z, 4'h2,
          (c >= 10 && c % 5 == 0) ? 4'h2 : Z, 1'b0);
    add(41, 1'b1, Z, 4'h2, 10, 4'h2, 5, Z, Z, Z, Z, Z, Z, Z, 1'b0);
    // Clear race and overrun on ch2, periodic from 50 step 2
    add(0,  1'b1, 4'h4, Z,    50, 4'h4, 2, 4'h4, Z,    Z,    Z,    Z,    4'h4, Z,    1'b0);
    add(50, 1'b1, Z,    Z,    50, 4'h4, 2, 4'h4, Z,    4'h4, 4'h4, Z,    4'h4, 4'h4, 1'b0);
    add(51, 1'b1, Z,    Z,    50, 4'h4, 2, 4'h4, Z,    Z,    4'h4, Z,    4'h4, Z,    1'b1);
    add(52, 1'b1, Z,    Z,    50, 4'h4, 2, 4'h4, Z,    Z,    4'h4, 4'h4, 4'h4, 4'h4, 1'b1);
    add(53, 1'b1, Z,    Z,    50, 4'h4, 2, 4'h4, Z,    4'h4, Z,    Z,    4'h4, Z,    1'b0);
    add(54, 1'b1, Z,    Z,    50, 4'h4, 2, 4'h4, Z,    Z,    4'h4, Z,    4'h4, 4'h4, 1'b1);
    add(55, 1'b1, Z,    4'h4, 50, 4'h4, 2, 4'h4, 4'h4, Z,    4'h4, Z,    Z,    Z,    1'b0);
    run_table();

    // VIC follows mask and int_clr combinationally within the cycle
    ch_ld = '0; ch_dis = '0;
    intr_mask = '0; #1;
    chk("unmask vic", 32'(rtc0_vic_intr), 32'h1);
    int_clr = 4'h4; #1;
    chk("clr vic same cycle", 32'(rtc0_vic_intr), 32'h0);
    @(posedge clk); #1;
    chk("clr flag", 32'(int_flag), 32'h0);
    int_clr = '0;

    // Load/disarm collisions on ch3, cnt_en gating, multi-channel hit
    add(0,   1'b1, 4'h8, Z,    100, Z,    0, 4'h8, Z, Z,    Z,    Z, 4'h8, Z,    1'b0);
    add(100, 1'b1, 4'h8, Z,    200, Z,    0, 4'h8, Z, Z,    4'h8, Z, 4'h8, 4'h8, 1'b1);
    add(150, 1'b1, Z,    Z,    200, Z,    0, 4'h8, Z, Z,    4'h8, Z, 4'h8, Z,    1'b1);
    add(200, 1'b1, Z,    Z,    200, Z,    0, 4'h8, Z, 4'h8, 4'h8, Z, Z,    4'h8, 1'b0);
    add(201, 1'b1, Z,    Z,    200, Z,    0, 4'h8, Z, Z,    4'h8, Z, Z,    Z,    1'b1);
    add(201, 1'b1, 4'h8, 4'h8, 300, Z,    0, 4'h8, Z, 4'h8, Z,    Z, Z,    Z,    1'b0);
    add(300, 1'b0, 4'h8, Z,    300, Z,    0, 4'h8, Z, Z,    Z,    Z, 4'h8, Z,    1'b0);
    add(300, 1'b0, Z,    Z,    300, Z,    0, 4'h8, Z, Z,    Z,    Z, 4'h8, Z,    1'b0);
    add(300, 1'b1, Z,    Z,    300, Z,    0, 4'h8, Z, Z,    4'h8, Z, Z,    4'h8, 1'b1);
    add(300, 1'b1, Z,    Z,    300, Z,    0, 4'h8, Z, Z,    4'h8, Z, Z,    Z,    1'b1);
    add(300, 1'b1, 4'h8, Z,    400, 4'h8, 7, 4'h8, Z, 4'h8, Z,    Z, 4'h8, Z,    1'b0);
    add(400, 1'b1, Z,    4'h8, 400, 4'h8, 7, 4'h8, Z, Z,    4'h8, Z, Z,    4'h8, 1'b1);
    add(407, 1'b1, Z,    Z,    400, 4'h8, 7, 4'h8, Z, Z,    4'h8, Z, Z,    Z,    1'b1);
    add(0,   1'b1, 4'hF, Z,    500, Z,    0, 4'hF, Z, 4'hF, Z,    Z, 4'hF, Z,    1'b0);
    add(500, 1'b1, Z,    Z,    500, Z,    0, 4'hF, Z, Z,    4'hF, Z, Z,    4'hF, 1'b1);
    add(501, 1'b1, Z,    Z,    500, Z,    0, 4'hF, Z, Z,    4'hF, Z, Z,    Z,    1'b1);
    run_table();

    // 8-bit wrap: 250 + 10 -> 4
    ch_ld = '0; ch_dis = '0;
    n_ld = 1'b1; n_ld_val = 8'd250; n_mode = 1'b1; n_period = 8'd10;
    n_ien = 1'b1; n_cnt_en = 1'b1; n_count = 8'd0;
    @(posedge clk); #1;
    n_ld = 1'b0;
    chk("w8 armed", 32'(n_armed), 32'h1);
    n_count = 8'd250;
    @(posedge clk); #1;
    chk("w8 trig@250", 32'(n_trig), 32'h1);
    chk("w8 flag@250", 32'(n_flag), 32'h1);
    n_count = 8'd255;
    @(posedge clk); #1;
    chk("w8 trig@255", 32'(n_trig), 32'h0);
    n_count = 8'd4;
    @(posedge clk); #1;
    chk("w8 trig@4", 32'(n_trig), 32'h1);
    chk("w8 ovr@4", 32'(n_ovr), 32'h1);
    n_count = 8'd14;
    @(posedge clk); #1;
    chk("w8 trig@14", 32'(n_trig), 32'h1);
    n_cnt_en = 1'b0;

    // Async reset mid-run with all channels armed and flagged
    ch_ld = 4'hF; ld_val = 600; ch_mode = 4'hF; ch_period = {4{32'd1}};
    intr_en = 4'hF; intr_mask = '0; int_clr = '0; count_val = 0; cnt_en = 1'b1;
    @(posedge clk); #1;
    ch_ld = '0;
    chk("pre-rst armed", 32'(ch_armed), 32'hF);
    count_val = 600;
    @(posedge clk); #1;
    chk("pre-rst trig", 32'(rtc_etb_trig), 32'hF);
    chk("pre-rst ovr", 32'(ovr_flag), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst flag", 32'(int_flag), 32'h0);
    chk("rst ovr", 32'(ovr_flag), 32'h0);
    chk("rst armed", 32'(ch_armed), 32'h0);
    chk("rst trig", 32'(rtc_etb_trig), 32'h0);
    chk("rst vic", 32'(rtc0_vic_intr), 32'h0);
    #2 rst_n = 1'b1;
    count_val = 601;
    @(posedge clk); #1;
    chk("post-rst trig", 32'(rtc_etb_trig), 32'h0);
    chk("post-rst armed", 32'(ch_armed), 32'h0);
    ch_ld = 4'h1; ld_val = 700; count_val = 0;
    @(posedge clk); #1;
    ch_ld = '0; count_val = 700;
    @(posedge clk); #1;
    chk("rearm trig", 32'(rtc_etb_trig), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
